// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter that drives a one-cycle load strobe into a shared register,
// waits out its load latency, then acknowledges the winning requester.
module reg_load_arbiter #(
  parameter int NREQ     = 4,
  parameter int DATA_W   = 4,
  parameter int LOAD_LAT = 2,
  parameter int PTR_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          ack,
  output logic                     reg_load,
  output logic [DATA_W-1:0]        reg_data,
  output logic                     busy,
  output logic [PTR_W-1:0]         grant_idx,
  output logic [7:0]               xfer_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, ACK} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt;
  logic [PTR_W-1:0] ptr, ptr_nxt, win_idx;
  logic             win_vld, grant, done;

  function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] p, input int i);
    int k;
    k = int'(p) + i;
    if (k >= NREQ) k = k - NREQ;
    return PTR_W'(k);
  endfunction

  // First requester at or after ptr, wrapping; ptr itself is highest priority.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_vld && req[rot_idx(ptr, i)]) begin
        win_vld = 1'b1;
        win_idx = rot_idx(ptr, i);
      end
    end
  end

  assign ptr_nxt = (grant_idx == PTR_W'(NREQ-1)) ? '0 : grant_idx + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (win_vld) begin
        state_nxt = LOAD;
        grant     = 1'b1;
      end
      LOAD: state_nxt = WAIT;
      WAIT: if (cnt == '0) begin
        state_nxt = ACK;
        done      = 1'b1;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the transition that enters each state, so
  // they line up with the state they describe and never see req directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      ptr       <= '0;
      ack       <= '0;
      reg_load  <= 1'b0;
      reg_data  <= '0;
      busy      <= 1'b0;
      grant_idx <= '0;
      xfer_cnt  <= '0;
    end else begin
      reg_load <= grant;
      busy     <= (state_nxt != IDLE);
      ack      <= '0;
      if (grant) begin
        grant_idx <= win_idx;
        reg_data  <= req_data[win_idx*DATA_W +: DATA_W];
      end
      if (state == LOAD)                 cnt <= 4'(LOAD_LAT-1);
      else if (state == WAIT && cnt != '0) cnt <= cnt - 4'd1;
      if (done) begin
        ack[grant_idx] <= 1'b1;
        ptr            <= ptr_nxt;
        xfer_cnt       <= xfer_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Directed bench for reg_load_arbiter: transfer-timeline model checked every cycle
// plus literal expectations for each scenario.
module tb_reg_load_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 4;
  localparam int LL   = 2;
  localparam int PW   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   ack;
  logic              reg_load;
  logic [DW-1:0]     reg_data;
  logic              busy;
  logic [PW-1:0]     grant_idx;
  logic [7:0]        xfer_cnt;

  reg_load_arbiter #(.NREQ(NREQ), .DATA_W(DW), .LOAD_LAT(LL), .PTR_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .reg_load(reg_load), .reg_data(reg_data), .busy(busy),
    .grant_idx(grant_idx), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: a transfer is a timeline of phases counted from the grant edge.
  // phase 0 idle, 1 load strobe, 2..LL+1 latency wait, LL+2 ack.
  int            m_phase = 0;
  logic [PW-1:0] m_gidx = '0;
  logic [PW-1:0] m_ptr = '0;
  logic [DW-1:0] m_data = '0;
  logic [7:0]    m_cnt = '0;

  function automatic int pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
    for (int i = 0; i < NREQ; i++)
      if (r[(int'(p) + i) % NREQ]) return (int'(p) + i) % NREQ;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_gidx <= '0; m_ptr <= '0; m_data <= '0; m_cnt <= '0;
    end else if (m_phase == 0) begin
      if (pick(req, m_ptr) >= 0) begin
        m_phase <= 1;
        m_gidx  <= PW'(pick(req, m_ptr));
        m_data  <= req_data[pick(req, m_ptr)*DW +: DW];
      end
    end else if (m_phase == LL+2) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
      if (m_phase == LL+1) begin
        m_cnt <= m_cnt + 8'd1;
        m_ptr <= PW'((int'(m_gidx) + 1) % NREQ);
      end
    end
  end

  logic prev_ld = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("reg_load", reg_load, m_phase == 1);
      chk("busy", busy, m_phase != 0);
      chk("ack", ack, (m_phase == LL+2) ? (32'd1 << m_gidx) : 32'd0);
      chk("grant_idx", grant_idx, m_gidx);
      chk("reg_data", reg_data, m_data);
      chk("xfer_cnt", xfer_cnt, m_cnt);
      chk("reg_load_twice", prev_ld & reg_load, 0);
      prev_ld <= reg_load;
    end
  end

  task automatic wait_ack(input int budget, output int n);
    n = 0;
    while (ack == '0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("ack_timeout", ack != '0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, last;
    int exp_g[5];
    exp_g = '{0, 1, 2, 3, 0};
    last  = 0;

    // Reset held with every requester asking
    req_data = {4'h4, 4'h3, 4'h2, 4'h5};
    req      = 4'b1111;
    @(negedge clk);
    chk_en = 1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_reg_load", reg_load, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ack", ack, 0);
      chk("rst_xfer_cnt", xfer_cnt, 0);
      chk("rst_grant_idx", grant_idx, 0);
      chk("rst_reg_data", reg_data, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant_idx", grant_idx, 0);
    chk("first_load", reg_load, 1);
    chk("first_data", reg_data, 4'h5);
    req = '0;
    wait_idle();

    // Single transfer from requester 2
    do_reset();
    req_data = {4'h7, 4'hA, 4'h3, 4'h1};
    req      = 4'b0100;
    @(negedge clk);
    chk("single_load", reg_load, 1);
    chk("single_data", reg_data, 4'hA);
    wait_ack(10, n);
    chk("single_ack_latency", n, 3);
    chk("single_ack", ack, 4'b0100);
    req = '0;
    @(negedge clk);
    chk("single_load_low", reg_load, 0);
    chk("single_xfer_cnt", xfer_cnt, 1);
    chk("single_grant_idx", grant_idx, 2);
    chk("single_data_kept", reg_data, 4'hA);
    wait_idle();

    // Round robin with all four requesting
    do_reset();
    req_data = {4'h4, 4'h3, 4'h2, 4'h1};
    req      = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(10, n);
      chk("rr_grant", grant_idx, exp_g[i]);
      chk("rr_data", reg_data, exp_g[i] + 1);
      chk("rr_ack", ack, 32'd1 << exp_g[i]);
      if (i > 0) chk("rr_spacing", cyc - last, 5);
      last = cyc;
      if (i == 4) req = '0;
      @(negedge clk);
    end
    wait_idle();

    // Winner drops during WAIT; a late request waits for the next IDLE
    do_reset();
    req_data = {4'hC, 4'h0, 4'h9, 4'h0};
    req      = 4'b0010;
    @(negedge clk);
    chk("drop_load", reg_load, 1);
    @(negedge clk);
    chk("drop_in_wait", busy & ~reg_load, 1);
    req = 4'b1000;
    wait_ack(10, n);
    chk("drop_ack", ack, 4'b0010);
    @(negedge clk);
    chk("drop_idle_noload", reg_load, 0);
    @(negedge clk);
    chk("late_load", reg_load, 1);
    chk("late_grant", grant_idx, 3);
    chk("late_data", reg_data, 4'hC);
    wait_ack(10, n);
    chk("late_ack", ack, 4'b1000);
    req = '0;
    wait_idle();

    // 256 back-to-back transfers wrap the counter
    do_reset();
    req_data = {4'h4, 4'h3, 4'h2, 4'h1};
    req      = 4'b1111;
    for (int i = 1; i <= 256; i++) begin
      wait_ack(10, n);
      if (ack == '0) break;
      if (i == 255) chk("wrap_cnt_255", xfer_cnt, 255);
      if (i == 256) begin
        chk("wrap_cnt_0", xfer_cnt, 0);
        req = '0;
      end
      @(negedge clk);
    end
    wait_idle();

    // Reset asserted mid-WAIT
    do_reset();
    req_data = {4'h1, 4'h2, 4'h3, 4'h6};
    req      = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    chk("mid_in_wait", busy & ~reg_load, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_load", reg_load, 0);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_cnt", xfer_cnt, 0);
    chk("mid_rst_grant", grant_idx, 0);
    chk("mid_rst_data", reg_data, 0);
    req = 4'b1001;
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_no_ack", ack, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_load", reg_load, 1);
    chk("restart_grant", grant_idx, 0);
    chk("restart_data", reg_data, 4'h6);
    wait_ack(10, n);
    chk("restart_ack", ack, 4'b0001);
    req = '0;
    @(negedge clk);
    chk("restart_cnt", xfer_cnt, 1);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
